seq_code_decoder: RTL
=====================

SEQ_CODE_DECODER -- requirements
Module: seq_code_decoder

Interface
- REQ-001: Parameter CODE_W, default 7: width of each input code word.
- REQ-002: Parameter SEQ_LEN, default 4, range 2..16: number of codes in the target sequence.
- REQ-003: Parameter MAX_FAIL, default 3, at least 1: consecutive mismatches that trigger lockout.
- REQ-004: Parameter LOCK_CYCLES, default 16, at least 1: lockout duration in clk cycles.
- REQ-005: Parameter TIMEOUT, default 8, at least 1: idle cycles allowed between codes before progress is abandoned.
- REQ-006: clk  input  1  clock; all state changes on the rising edge.
- REQ-007: Reset  input  1  synchronous, active-high reset.
- REQ-008: Entrada  input  CODE_W  code word, sampled only when Controle=1.
- REQ-009: Controle  input  1  code-valid strobe.
- REQ-010: prog_en  input  1  table-write enable.
- REQ-011: prog_idx  input  $clog2(SEQ_LEN)  table entry to write.
- REQ-012: prog_code  input  CODE_W  value to write.
- REQ-013: Saida  output  $clog2(SEQ_LEN+1)  progress, i.e. the number of codes matched so far.
- REQ-014: match  output  1  one-cycle pulse when the full sequence completes.
- REQ-015: error  output  1  one-cycle pulse on a mismatch.
- REQ-016: locked  output  1  high while in LOCKOUT.

Function
- REQ-017: The block SHALL hold a code table of SEQ_LEN entries, each CODE_W bits wide.
- REQ-018: The FSM SHALL have three states: TRACK (progress 0..SEQ_LEN-1), LOCKOUT, PROG.
- REQ-019: PROG SHALL be active in any cycle with prog_en=1.
  - The table entry at prog_idx is written with prog_code.
  - Saida and fail_cnt are cleared.
  - Controle is ignored.
  - PROG has priority over every other event, including an active LOCKOUT, which it aborts.
- REQ-020: In TRACK, Controle=1 with Entrada equal to table[Saida] SHALL increment Saida on the next edge.
- REQ-021: If that increment would reach SEQ_LEN, the block SHALL instead:
  - drive match=1 for exactly 1 cycle,
  - set Saida=0,
  - set fail_cnt=0.
- REQ-022: In TRACK, Controle=1 with Entrada not equal to table[Saida] SHALL:
  - drive error=1 for 1 cycle,
  - increment fail_cnt,
  - set Saida to 1 if Entrada equals table[0], otherwise to 0.
- REQ-023: When a mismatch brings fail_cnt to MAX_FAIL, the block SHALL enter LOCKOUT on the next edge.
  - locked=1, Saida=0, fail_cnt=0.
  - The error pulse is still emitted.
- REQ-024: In LOCKOUT, Controle SHALL be ignored, with no error and no match.
- REQ-025: LOCKOUT SHALL last exactly LOCK_CYCLES cycles, after which the block returns to TRACK with Saida=0.
- REQ-026: The timeout counter SHALL behave as follows.
  - It counts cycles while Saida>0 and Controle=0.
  - It clears on any Controle=1 and whenever Saida=0.
  - On reaching TIMEOUT, Saida is set to 0 with no error pulse and no change to fail_cnt.
- REQ-027: If the timeout expires in the same cycle as Controle=1, the code SHALL be evaluated and the timeout ignored.
- REQ-028: A successful match SHALL be the only event that clears fail_cnt in TRACK; fail_cnt counts consecutive failures between matches.
- REQ-029: match and error SHALL never be high in the same cycle.
- REQ-030: Latency SHALL be one cycle: outputs reflect a code on the edge after the one at which it was sampled, and back-to-back codes are accepted every cycle.
- REQ-031: All outputs SHALL be registered.

Reset
- REQ-032: Reset=1 at a rising edge SHALL force:
  - TRACK state,
  - Saida=0, match=0, error=0, locked=0,
  - fail_cnt=0 and the timeout counter at 0,
  - table[i]=i+1 for i=0..SEQ_LEN-1.
- REQ-033: Reset SHALL have priority over prog_en and Controle and SHALL abort LOCKOUT immediately.

Verification
- REQ-034: Default parameters: reset, then codes 1,2,3,4 on consecutive cycles -> Saida 1,2,3; match pulses 1 cycle on the 4th edge; Saida=0.
- REQ-035: Codes 1,2,9 -> error pulse; Saida=0. Then codes 1,2,1 -> error pulse; Saida=1 (restart on table[0]).
- REQ-036: Three consecutive bad codes (9,9,9) -> 3 error pulses; locked=1 for exactly 16 cycles. Code 1 during lockout -> no effect. Then Saida=0 and locked=0.
- REQ-037: Code 1, then 8 idle cycles -> Saida returns to 0 with no error pulse. Code 1, 7 idle cycles, then code 2 -> Saida=2.
- REQ-038: Program table = 0x55,0x2A,0x7F,0x01 via prog_en, with Controle=1 asserted simultaneously -> no progress change. Then sequence 0x55,0x2A,0x7F,0x01 -> match; old sequence 1,2,3,4 -> error.
- REQ-039: Reset asserted mid-sequence (Saida=2) and mid-lockout -> next cycle Saida=0, locked=0, default table restored.

Source files
------------

// File: rtl/seq_code_decoder.sv
// Sequence code decoder: tracks Entrada strobes against a programmable code table,
// pulsing match on a complete sequence, error on a mismatch, and locking out after repeated failures.
module seq_code_decoder #(
    parameter int CODE_W      = 7,
    parameter int SEQ_LEN     = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int TIMEOUT     = 8
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic [CODE_W-1:0]            Entrada,
    input  logic                         Controle,
    input  logic                         prog_en,
    input  logic [$clog2(SEQ_LEN)-1:0]   prog_idx,
    input  logic [CODE_W-1:0]            prog_code,
    output logic [$clog2(SEQ_LEN+1)-1:0] Saida,
    output logic                         match,
    output logic                         error,
    output logic                         locked
);

    localparam int IW = $clog2(SEQ_LEN);
    localparam int SW = $clog2(SEQ_LEN + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {TRACK, LOCKOUT, PROG} state_t;

    state_t            state;
    logic [CODE_W-1:0] code_tbl [SEQ_LEN];
    logic [CODE_W-1:0] expect_code;
    logic [FW-1:0]     fail_cnt;
    logic [LW-1:0]     lock_cnt;
    logic [TW-1:0]     tmo_cnt;

    // Saida never exceeds SEQ_LEN-1, so a compare-select avoids an out-of-range index.
    always_comb begin
        expect_code = '0;
        for (int unsigned i = 0; i < SEQ_LEN; i++)
            if (Saida == SW'(i))
                expect_code = code_tbl[i];
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < SEQ_LEN; i++)
                code_tbl[i] <= CODE_W'(i + 1);
        end else if (prog_en) begin
            for (int unsigned i = 0; i < SEQ_LEN; i++)
                if (prog_idx == IW'(i))
                    code_tbl[i] <= prog_code;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= TRACK;
            Saida    <= '0;
            match    <= 1'b0;
            error    <= 1'b0;
            locked   <= 1'b0;
            fail_cnt <= '0;
            lock_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            match <= 1'b0;
            error <= 1'b0;
            if (prog_en) begin
                state    <= PROG;
                Saida    <= '0;
                fail_cnt <= '0;
                lock_cnt <= '0;
                tmo_cnt  <= '0;
                locked   <= 1'b0;
            end else begin
                case (state)
                    LOCKOUT: begin
                        tmo_cnt <= '0;
                        if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
                            state    <= TRACK;
                            locked   <= 1'b0;
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= TRACK;
                        if (Controle) begin
                            tmo_cnt <= '0;
                            if (Entrada == expect_code) begin
                                if (Saida == SW'(SEQ_LEN - 1)) begin
                                    match    <= 1'b1;
                                    Saida    <= '0;
                                    fail_cnt <= '0;
                                end else begin
                                    Saida <= Saida + 1'b1;
                                end
                            end else begin
                                error <= 1'b1;
                                if (fail_cnt == FW'(MAX_FAIL - 1)) begin
                                    state    <= LOCKOUT;
                                    locked   <= 1'b1;
                                    lock_cnt <= '0;
                                    Saida    <= '0;
                                    fail_cnt <= '0;
                                end else begin
                                    fail_cnt <= fail_cnt + 1'b1;
                                    Saida    <= (Entrada == code_tbl[0]) ? SW'(1) : '0;
                                end
                            end
                        end else if (Saida != '0) begin
                            // A strobe in the expiry cycle takes the branch above instead.
                            if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                                Saida   <= '0;
                                tmo_cnt <= '0;
                            end else begin
                                tmo_cnt <= tmo_cnt + 1'b1;
                            end
                        end else begin
                            tmo_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule
